// File: rtl/pattern_detector.sv
// Serial pattern detector: masked compare of the last WIDTH sampled bits against a loaded pattern.
// match_pulse is registered and rises on the edge that samples the final bit; no backpressure.
module pattern_detector #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             x_in,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic             overlap,
  output logic             match_pulse,
  output logic             y_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [HW-1:0] HOLD = HW'(HOLD_CYCLES);

  typedef enum logic {S_FILL, S_ARMED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_q, mask_q;
  logic [WIDTH-1:0] hist, hist_n, hist_sh;
  logic [FW-1:0]    fill, fill_n, fill_inc;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [CNT_W-1:0] cnt_n;
  logic             match, y_n;

  assign count_sat = &match_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_FILL;
      pat_q       <= '0;
      mask_q      <= '0;
      hist        <= '0;
      fill        <= '0;
      hold_cnt    <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
      y_out       <= 1'b0;
    end else begin
      state       <= state_n;
      hist        <= hist_n;
      fill        <= fill_n;
      hold_cnt    <= hold_n;
      match_count <= cnt_n;
      match_pulse <= match;
      y_out       <= y_n;
      if (load) begin
        pat_q  <= pattern;
        mask_q <= mask;
      end
    end
  end

  always_comb begin
    hist_sh  = {hist[WIDTH-2:0], x_in};
    fill_inc = (state == S_ARMED) ? FULL : fill + 1'b1;
    match    = enable && !load && (fill_inc == FULL) && (mask_q != '0) &&
               (((hist_sh ^ pat_q) & mask_q) == '0);
    state_n  = state;
    hist_n   = hist;
    fill_n   = fill;
    hold_n   = hold_cnt;
    cnt_n    = match_count;
    y_n      = 1'b0;
    if (load) begin
      state_n = S_FILL;
      hist_n  = '0;
      fill_n  = '0;
      hold_n  = '0;
      cnt_n   = '0;
    end else begin
      if (enable) begin
        hist_n = hist_sh;
        // Non-overlapping search demands WIDTH fresh bits; history keeps shifting regardless.
        if (match && !overlap) begin
          fill_n  = '0;
          state_n = S_FILL;
        end else begin
          fill_n  = fill_inc;
          state_n = (fill_inc == FULL) ? S_ARMED : S_FILL;
        end
      end
      if (match) begin
        hold_n = HOLD;
        y_n    = 1'b1;
        if (!count_sat) cnt_n = match_count + 1'b1;
      end else if (hold_cnt != '0) begin
        hold_n = hold_cnt - 1'b1;
        y_n    = (hold_cnt > HW'(1));
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector (WIDTH=4, CNT_W=2, HOLD_CYCLES=3): vector table, corner sequences, random vs model.
module tb_pattern_detector;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int HOLD = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0, x_in = 1'b0, load = 1'b0, overlap = 1'b0;
  logic [W-1:0]  pattern = '0, mask = '0;
  logic          match_pulse, y_out, count_sat;
  logic [CW-1:0] match_count;

  int tests = 0;
  int fails = 0;

  pattern_detector #(.WIDTH(W), .CNT_W(CW), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .x_in(x_in), .load(load),
    .pattern(pattern), .mask(mask), .overlap(overlap),
    .match_pulse(match_pulse), .y_out(y_out), .match_count(match_count), .count_sat(count_sat)
  );

  always #5 clock = ~clock;

  // Reference model: list of sampled bits, count of fresh bits, cycles since last match.
  logic [W-1:0] m_pat, m_msk;
  bit           bits[$];
  int           fresh, m_cnt, since;
  bit           m_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input logic [W-1:0] pat, input logic [W-1:0] msk);
    m_pat = pat; m_msk = msk;
    bits.delete();
    fresh = 0; m_cnt = 0; since = 1000; m_pulse = 0;
  endtask

  task automatic model_edge(input logic en, input logic x, input logic ld,
                            input logic [W-1:0] pat, input logic [W-1:0] msk, input logic ov);
    bit ok;
    if (ld) begin
      model_clear(pat, msk);
    end else begin
      ok = 0;
      if (en) begin
        bits.push_back(x);
        if (bits.size() > W) void'(bits.pop_front());
        fresh++;
        if (fresh >= W && m_msk != 0) begin
          ok = 1;
          for (int i = 0; i < W; i++)
            if (m_msk[i] && bits[W-1-i] != m_pat[i]) ok = 0;
        end
      end
      m_pulse = ok;
      if (ok) begin
        since = 0;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!ov) fresh = 0;
      end else if (since < 1000) begin
        since++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pulse"}, match_pulse, m_pulse);
    chk({tag, ".y"}, y_out, since < HOLD);
    chk({tag, ".cnt"}, match_count, m_cnt);
    chk({tag, ".sat"}, count_sat, m_cnt == (1 << CW) - 1);
  endtask

  task automatic cyc(input string tag, input logic en, input logic x, input logic ld,
                     input logic [W-1:0] pat, input logic [W-1:0] msk, input logic ov);
    @(negedge clock);
    enable = en; x_in = x; load = ld; pattern = pat; mask = msk; overlap = ov;
    @(posedge clock);
    model_edge(en, x, ld, pat, msk, ov);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic en, x, ld, ov;
    logic [W-1:0] pat, msk;
    logic pulse, y;
    logic [CW-1:0] cnt;
  } vec_t;

  function automatic vec_t v(input logic en, input logic x, input logic ld, input logic ov,
                             input logic [W-1:0] pat, input logic [W-1:0] msk,
                             input logic pulse, input logic y, input logic [CW-1:0] cnt);
    vec_t r;
    r.en = en; r.x = x; r.ld = ld; r.ov = ov; r.pat = pat; r.msk = msk;
    r.pulse = pulse; r.y = y; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[27];
  int   pulses;
  logic [W-1:0] seq;
  int   exp_cnt[4];

  initial begin
    // Basic match, overlapping search, then non-overlapping on the same stream.
    tbl[0]  = v(0,0,1,0, 4'b1011,4'b1111, 0,0,0);
    tbl[1]  = v(1,1,0,0, 4'b1011,4'b1111, 0,0,0);
    tbl[2]  = v(1,0,0,0, 4'b1011,4'b1111, 0,0,0);
    tbl[3]  = v(1,1,0,0, 4'b1011,4'b1111, 0,0,0);
    tbl[4]  = v(1,1,0,0, 4'b1011,4'b1111, 1,1,1);
    tbl[5]  = v(0,0,0,0, 4'b1011,4'b1111, 0,1,1);
    tbl[6]  = v(0,1,0,0, 4'b1011,4'b1111, 0,1,1);
    tbl[7]  = v(0,0,0,0, 4'b1011,4'b1111, 0,0,1);
    tbl[8]  = v(0,0,1,1, 4'b1011,4'b1111, 0,0,0);
    tbl[9]  = v(1,1,0,1, 4'b0000,4'b0000, 0,0,0);
    tbl[10] = v(1,0,0,1, 4'b0000,4'b0000, 0,0,0);
    tbl[11] = v(1,1,0,1, 4'b0000,4'b0000, 0,0,0);
    tbl[12] = v(1,1,0,1, 4'b0000,4'b0000, 1,1,1);
    tbl[13] = v(1,0,0,1, 4'b0000,4'b0000, 0,1,1);
    tbl[14] = v(1,1,0,1, 4'b0000,4'b0000, 0,1,1);
    tbl[15] = v(1,1,0,1, 4'b0000,4'b0000, 1,1,2);
    tbl[16] = v(0,0,0,1, 4'b0000,4'b0000, 0,1,2);
    tbl[17] = v(0,0,0,1, 4'b0000,4'b0000, 0,1,2);
    tbl[18] = v(0,0,0,1, 4'b0000,4'b0000, 0,0,2);
    tbl[19] = v(0,0,1,0, 4'b1011,4'b1111, 0,0,0);
    tbl[20] = v(1,1,0,0, 4'b1011,4'b1111, 0,0,0);
    tbl[21] = v(1,0,0,0, 4'b1011,4'b1111, 0,0,0);
    tbl[22] = v(1,1,0,0, 4'b1011,4'b1111, 0,0,0);
    tbl[23] = v(1,1,0,0, 4'b1011,4'b1111, 1,1,1);
    tbl[24] = v(1,0,0,0, 4'b1011,4'b1111, 0,1,1);
    tbl[25] = v(1,1,0,0, 4'b1011,4'b1111, 0,1,1);
    tbl[26] = v(1,1,0,0, 4'b1011,4'b1111, 0,0,1);

    model_clear('0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset.pulse", match_pulse, 0);
    chk("reset.y", y_out, 0);
    chk("reset.cnt", match_count, 0);
    chk("reset.sat", count_sat, 0);
    @(negedge clock) reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clock);
      enable = tbl[i].en; x_in = tbl[i].x; load = tbl[i].ld;
      overlap = tbl[i].ov; pattern = tbl[i].pat; mask = tbl[i].msk;
      @(posedge clock);
      model_edge(tbl[i].en, tbl[i].x, tbl[i].ld, tbl[i].pat, tbl[i].msk, tbl[i].ov);
      #1;
      chk($sformatf("tbl%0d.pulse", i), match_pulse, tbl[i].pulse);
      chk($sformatf("tbl%0d.y", i), y_out, tbl[i].y);
      chk($sformatf("tbl%0d.cnt", i), match_count, tbl[i].cnt);
    end

    // Masked compare: 1001 under mask 1001 accepts 1xx1 windows.
    cyc("mask.ld", 0, 0, 1, 4'b1001, 4'b1001, 0);
    seq = 4'b1001;
    for (int i = W-1; i >= 0; i--) cyc("mask.a", 1, seq[i], 0, 4'b1001, 4'b1001, 0);
    seq = 4'b1111;
    for (int i = W-1; i >= 0; i--) cyc("mask.b", 1, seq[i], 0, 4'b1001, 4'b1001, 0);
    chk("mask.count", match_count, 2);
    cyc("mask0.ld", 0, 0, 1, 4'b1001, 4'b0000, 1);
    for (int i = 0; i < 12; i++) cyc("mask0", 1, 1'($urandom), 0, 4'b1001, 4'b0000, 1);
    chk("mask0.count", match_count, 0);

    // Enable gaps with x_in toggling while disabled.
    cyc("gap.ld", 0, 0, 1, 4'b1011, 4'b1111, 0);
    seq = 4'b1011;
    pulses = 0;
    for (int i = W-1; i >= 0; i--) begin
      cyc("gap.bit", 1, seq[i], 0, 4'b1011, 4'b1111, 0);
      pulses += int'(match_pulse);
      if (i == 0) chk("gap.pulse_on_4th", match_pulse, 1);
      cyc("gap.idle0", 0, 1, 0, 4'b1011, 4'b1111, 0);
      pulses += int'(match_pulse);
      cyc("gap.idle1", 0, 0, 0, 4'b1011, 4'b1111, 0);
      pulses += int'(match_pulse);
    end
    chk("gap.pulses", pulses, 1);

    // Retrigger and counter saturation with seven ones.
    exp_cnt = '{1, 2, 3, 3};
    cyc("sat.ld", 0, 0, 1, 4'b1111, 4'b1111, 1);
    for (int i = 1; i <= 7; i++) begin
      cyc("sat.bit", 1, 1, 0, 4'b1111, 4'b1111, 1);
      chk($sformatf("sat.pulse%0d", i), match_pulse, i >= 4);
      chk($sformatf("sat.y%0d", i), y_out, i >= 4);
      if (i >= 4) begin
        chk($sformatf("sat.cnt%0d", i), match_count, exp_cnt[i-4]);
        chk($sformatf("sat.sat%0d", i), count_sat, i >= 6);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      cyc("sat.tail", 0, 0, 0, 4'b1111, 4'b1111, 1);
      chk($sformatf("sat.tail_y%0d", i), y_out, i < HOLD);
    end

    // Asynchronous reset while y_out is held.
    cyc("rst.ld", 0, 0, 1, 4'b1011, 4'b1111, 0);
    seq = 4'b1011;
    for (int i = W-1; i >= 0; i--) cyc("rst.bit", 1, seq[i], 0, 4'b1011, 4'b1111, 0);
    chk("rst.y_before", y_out, 1);
    @(negedge clock);
    enable = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst.async_pulse", match_pulse, 0);
    chk("rst.async_y", y_out, 0);
    chk("rst.async_cnt", match_count, 0);
    chk("rst.async_sat", count_sat, 0);
    @(negedge clock) reset = 1'b0;
    model_clear('0, '0);
    for (int i = W-1; i >= 0; i--) cyc("rst.after", 1, seq[i], 0, 4'b1011, 4'b1111, 0);
    chk("rst.after_cnt", match_count, 0);

    // load beats enable on the edge carrying the final pattern bit.
    cyc("pri.ld", 0, 0, 1, 4'b1011, 4'b1111, 0);
    cyc("pri.b1", 1, 1, 0, 4'b1011, 4'b1111, 0);
    cyc("pri.b2", 1, 0, 0, 4'b1011, 4'b1111, 0);
    cyc("pri.b3", 1, 1, 0, 4'b1011, 4'b1111, 0);
    cyc("pri.b4", 1, 1, 1, 4'b1011, 4'b1111, 0);
    chk("pri.pulse", match_pulse, 0);
    chk("pri.cnt", match_count, 0);
    cyc("pri.next", 1, 1, 0, 4'b1011, 4'b1111, 0);
    chk("pri.no_match", match_pulse, 0);

    // Random stream against the model; pattern/mask/overlap pins wiggle freely between loads.
    for (int n = 0; n < 3000; n++) begin
      logic en, x, ld, ov;
      logic [W-1:0] p, m;
      en = ($urandom_range(0, 9) < 7);
      x  = 1'($urandom);
      ld = ($urandom_range(0, 99) < 3);
      ov = 1'($urandom);
      p  = W'($urandom);
      m  = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom);
      cyc("rand", en, x, ld, p, m, ov);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
